// File: rtl/hpdl_display_ctrl.sv
// HPDL-1414 multi-module display controller: byte stream into a character buffer,
// dirty-digit write scheduler with programmable setup/strobe/hold bus timing.
module hpdl_display_ctrl #(
    parameter int NUM_MODULES = 4,
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 3,
    parameter int HOLD_CYC    = 2,
    parameter int REFRESH_CYC = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    output logic                   busy,
    output logic [6:0]             HPDL_D,
    output logic [1:0]             HPDL_A,
    output logic [NUM_MODULES-1:0] HPDL_WR_N
);
    localparam int N  = 4 * NUM_MODULES;
    localparam int IW = $clog2(N);
    localparam int CW = 16;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [6:0]             r_buf [N];
    logic [N-1:0]           r_dirty;
    logic [IW-1:0]          r_cursor, r_last, r_digit;
    logic [6:0]             r_d;
    logic [1:0]             r_a;
    logic [NUM_MODULES-1:0] r_wr_n;
    logic                   w_accept, w_hit, w_refresh, w_take;
    logic [IW-1:0]          w_hit_idx;
    logic [6:0]             w_char;
    logic [NUM_MODULES-1:0] w_sel;

    function automatic logic [6:0] fold_char(input logic [7:0] b);
        if (b[7] || (b < 8'h20)) return 7'h20;
        else if (b >= 8'h60)     return {2'b10, b[4:0]};
        else                     return b[6:0];
    endfunction

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= N) j = j - N;
        return IW'(j);
    endfunction

    assign in_ready = ~RST;
    assign w_accept = in_valid & ~RST;
    assign w_char   = fold_char(in_data);
    assign busy     = (r_state != S_IDLE) | (|r_dirty);
    assign HPDL_D    = r_d;
    assign HPDL_A    = r_a;
    assign HPDL_WR_N = r_wr_n;
    assign w_sel     = NUM_MODULES'(1) << (r_digit >> 2);
    assign w_take    = (r_state == S_IDLE) && w_hit;

    // Round-robin search: nearest dirty digit after the last one written wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (r_dirty[wrap_add(r_last, k)]) begin
                w_hit     = 1'b1;
                w_hit_idx = wrap_add(r_last, k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = '0;
                end
            end
            S_SETUP: begin
                if (r_cnt == CW'(SETUP_CYC - 1)) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STROBE: begin
                if (r_cnt == CW'(PULSE_CYC - 1)) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == CW'(HOLD_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // D/A are latched on leaving IDLE so later buffer writes cannot disturb a write in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_d     <= 7'h20;
            r_a     <= 2'b00;
            r_digit <= '0;
            r_last  <= IW'(N - 1);
            r_wr_n  <= '1;
        end else begin
            if (w_take) begin
                r_d     <= r_buf[w_hit_idx];
                r_a     <= ~w_hit_idx[1:0];
                r_digit <= w_hit_idx;
                r_last  <= w_hit_idx;
            end
            r_wr_n <= (w_state_nxt == S_STROBE) ? ~w_sel : '1;
        end
    end

    // Later assignments win: a buffer write in the same cycle keeps the dirty bit set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) r_buf[i] <= 7'h20;
            r_dirty  <= '1;
            r_cursor <= '0;
        end else begin
            if (w_take) r_dirty[w_hit_idx] <= 1'b0;
            if (w_refresh) r_dirty <= '1;
            if (w_accept) begin
                case (in_data)
                    8'h0C: begin
                        for (int i = 0; i < N; i++) r_buf[i] <= 7'h20;
                        r_dirty  <= '1;
                        r_cursor <= '0;
                    end
                    8'h0D: if (mode) r_cursor <= '0;
                    8'h08: if (mode && (r_cursor != '0)) r_cursor <= r_cursor - 1'b1;
                    default: begin
                        if (!mode) begin
                            for (int i = 0; i < N - 1; i++) r_buf[i] <= r_buf[i+1];
                            r_buf[N-1] <= w_char;
                            r_dirty    <= '1;
                        end else begin
                            r_buf[r_cursor]   <= w_char;
                            r_dirty[r_cursor] <= 1'b1;
                            r_cursor <= (r_cursor == IW'(N - 1)) ? '0 : r_cursor + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    generate
        if (REFRESH_CYC > 0) begin : g_refresh
            logic [31:0] r_ref_cnt;
            always_ff @(posedge CLK) begin
                if (RST) r_ref_cnt <= '0;
                else if (r_ref_cnt == 32'(REFRESH_CYC - 1)) r_ref_cnt <= '0;
                else r_ref_cnt <= r_ref_cnt + 1'b1;
            end
            assign w_refresh = (r_ref_cnt == 32'(REFRESH_CYC - 1));
        end else begin : g_no_refresh
            assign w_refresh = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_hpdl_display_ctrl.sv
// Bench for hpdl_display_ctrl: reference model predicts each digit write; a monitor
// decodes the HPDL bus and compares against the expected-write queue.
module tb_hpdl_display_ctrl;
    localparam int NM = 4;
    localparam int N  = 4 * NM;
    localparam int PULSE = 3;
    localparam int W  = 12;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          mode = 1'b0;
    logic          in_ready, busy;
    logic [6:0]    HPDL_D;
    logic [1:0]    HPDL_A;
    logic [NM-1:0] HPDL_WR_N;

    hpdl_display_ctrl #(.NUM_MODULES(NM), .SETUP_CYC(2), .PULSE_CYC(PULSE), .HOLD_CYC(2),
                        .REFRESH_CYC(0)) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .busy(busy), .HPDL_D(HPDL_D), .HPDL_A(HPDL_A), .HPDL_WR_N(HPDL_WR_N)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [6:0]   panel[N];
    bit           sb_en = 1'b1;

    // Reference model: character buffer, dirty set, cursor and last written digit.
    logic [6:0]   m_buf[N];
    bit           m_dirty[N];
    int           m_cursor, m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_char(input logic [7:0] b);
        if (b < 8'h20 || b >= 8'h80) return 7'h20;
        if (b >= 8'h60) return 7'(b - 8'h20);
        return 7'(b);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_buf[i] = 7'h20;
            m_dirty[i] = 1'b1;
        end
        m_cursor = 0;
        m_last = N - 1;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic m);
        if (b == 8'h0C) begin
            model_reset_buf();
        end else if (b == 8'h0D) begin
            if (m) m_cursor = 0;
        end else if (b == 8'h08) begin
            if (m && m_cursor > 0) m_cursor = m_cursor - 1;
        end else if (!m) begin
            for (int i = 0; i < N - 1; i++) m_buf[i] = m_buf[i+1];
            m_buf[N-1] = ref_char(b);
            for (int i = 0; i < N; i++) m_dirty[i] = 1'b1;
        end else begin
            m_buf[m_cursor] = ref_char(b);
            m_dirty[m_cursor] = 1'b1;
            m_cursor = (m_cursor + 1) % N;
        end
    endtask

    task automatic model_reset_buf();
        for (int i = 0; i < N; i++) begin
            m_buf[i] = 7'h20;
            m_dirty[i] = 1'b1;
        end
        m_cursor = 0;
    endtask

    // Queue the writes the scheduler owes: dirty digits in round-robin order after m_last.
    task automatic model_flush();
        int base;
        base = m_last;
        for (int k = 1; k <= N; k++) begin
            int d;
            d = (base + k) % N;
            if (m_dirty[d]) begin
                exp_q.push_back({3'(d / 4), 2'(3 - (d % 4)), m_buf[d]});
                m_dirty[d] = 1'b0;
                m_last = d;
            end
        end
    endtask

    function automatic int mod_of(input logic [NM-1:0] w);
        for (int i = 0; i < NM; i++) if (!w[i]) return i;
        return 7;
    endfunction

    // Monitor: decodes every WR_N pulse into {module, A, D} and pops the scoreboard.
    logic [NM-1:0] prev_wr_n = '1;
    logic [6:0]    prev_d, pulse_d;
    logic [1:0]    prev_a, pulse_a;
    logic [W-1:0]  got;
    int            width = 0;
    int            pulse_digit = 0;

    always @(negedge CLK) begin
        if (!sb_en) begin
            width = 0;
        end else if (HPDL_WR_N != '1) begin
            check("one_wr_low", $countones(~HPDL_WR_N), 1);
            if (prev_wr_n == '1) begin
                got = {3'(mod_of(HPDL_WR_N)), HPDL_A, HPDL_D};
                check("setup_stable", {prev_a, prev_d}, {HPDL_A, HPDL_D});
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write at %0t", got, $time);
                end else begin
                    check("write", got, exp_q.pop_front());
                end
                width = 1;
                pulse_d = HPDL_D;
                pulse_a = HPDL_A;
                pulse_digit = mod_of(HPDL_WR_N) * 4 + (3 - int'(HPDL_A));
            end else begin
                width++;
                check("d_stable", {HPDL_A, HPDL_D}, {pulse_a, pulse_d});
            end
        end else if (prev_wr_n != '1) begin
            check("pulse_width", width, PULSE);
            if (pulse_digit < N) panel[pulse_digit] = pulse_d;
        end
        prev_wr_n = HPDL_WR_N;
        prev_d = HPDL_D;
        prev_a = HPDL_A;
    end

    // Driver tasks: put_byte is called on a falling edge and drives immediately.
    task automatic put_byte(input logic [7:0] b, input logic m);
        in_data = b;
        mode = m;
        in_valid = 1'b1;
        check("in_ready", in_ready, 1);
        @(negedge CLK);
        in_valid = 1'b0;
        model_byte(b, m);
    endtask

    task automatic send(input logic [7:0] b, input logic m);
        @(negedge CLK);
        put_byte(b, m);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        check("idle_reached", (t < 5000), 1);
        check("writes_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_idle(input logic [7:0] b, input logic m);
        send(b, m);
        model_flush();
        wait_idle();
    endtask

    task automatic wait_wr(input logic low);
        int t;
        t = 0;
        while (((HPDL_WR_N != '1) != low) && t < 200) begin
            @(negedge CLK);
            t++;
        end
        check(low ? "wr_low_seen" : "wr_high_seen", (t < 200), 1);
    endtask

    task automatic check_panel(input string name);
        for (int d = 0; d < N; d++) check(name, panel[d], m_buf[d]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        logic [7:0] b;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_n", HPDL_WR_N, 4'hF);
        check("rst_d", HPDL_D, 7'h20);
        check("rst_a", HPDL_A, 2'b00);
        RST = 1'b0;
        model_reset();
        model_flush();
        #1;
        check("post_rst_in_ready", in_ready, 1);
        wait_idle();
        check_panel("blank_after_reset");

        // Cursor mode "ab"
        send_idle("a", 1'b1);
        send_idle("b", 1'b1);
        check("cursor_a", panel[0], 7'h41);
        check("cursor_b", panel[1], 7'h42);

        // Scroll mode, 17 bytes
        for (int i = 0; i < 17; i++) begin
            b = (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10);
            send_idle(b, 1'b0);
        end
        s = "123456789ABCDEFG";
        for (int d = 0; d < N; d++) check("scroll_final", panel[d], s[d]);

        // Cursor wrap at the last digit, backspace saturates at 0
        send_idle(8'h0D, 1'b1);
        for (int i = 0; i < N - 1; i++) send_idle(8'($urandom_range(8'h20, 8'h7F)), 1'b1);
        send_idle("X", 1'b1);
        send_idle(8'h08, 1'b1);
        send_idle("q", 1'b1);
        check("wrap_x", panel[15], 7'h58);
        check("backspace_sat", panel[0], 7'h51);
        check_panel("after_wrap");

        // Rewrite digit 3 during its own strobe
        send_idle(8'h0D, 1'b1);
        send_idle("a", 1'b1);
        send_idle("b", 1'b1);
        send_idle("c", 1'b1);
        send("d", 1'b1);
        model_flush();
        wait_wr(1'b1);
        put_byte(8'h08, 1'b1);
        put_byte("E", 1'b1);
        model_flush();
        wait_idle();
        check("rewrite_d3", panel[3], 7'h45);

        // Randomized stream
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: b = 8'h0C;
                1: b = 8'h0D;
                2: b = 8'h08;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_idle(b, 1'($urandom_range(0, 1)));
        end
        check_panel("random_stream");

        // Clear mid-write, then reset during a strobe
        send("Z", 1'b1);
        model_flush();
        wait_wr(1'b1);
        put_byte(8'h0C, 1'b1);
        model_flush();
        wait_wr(1'b0);
        wait_wr(1'b1);
        @(negedge CLK);
        sb_en = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        check("wr_n_after_rst", HPDL_WR_N, 4'hF);
        RST = 1'b0;
        exp_q.delete();
        model_reset();
        model_flush();
        @(negedge CLK);
        sb_en = 1'b1;
        wait_idle();
        for (int d = 0; d < N; d++) check("blank_after_midrst", panel[d], 7'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
